// File: rtl/sgd_pkg.sv
// Shared parameters, types and helpers for the SGD logistic-regression feed sequencer.
package sgd_pkg;

    localparam int N_FEAT    = 32;
    localparam int N_SAMPLES = 40;
    localparam int Q_FRAC    = 10;
    localparam int FW        = 16;
    localparam int LW        = 8;
    localparam int MEM_AW    = 11;
    localparam int IDX_W     = 5;

    localparam logic [MEM_AW-1:0] SAMPLE_STRIDE = MEM_AW'(N_FEAT + 1);
    localparam logic [5:0]        FEAT_CNT_LAST = 6'(N_FEAT);
    localparam logic [5:0]        SAMPLE_LAST   = 6'(N_SAMPLES - 1);
    localparam logic [IDX_W-1:0]  THETA_LAST    = IDX_W'(N_FEAT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KICK     = 3'd1,
        WAIT_REQ = 3'd2,
        FEAT     = 3'd3,
        LABEL    = 3'd4,
        DUMP     = 3'd5
    } feed_state_e;

    typedef logic signed [15:0] q6_10_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/sgd_theta_dump.sv
// Theta readback: walks the core's theta index and presents each word as a
// held ready/valid beat, with a one-cycle bubble between beats for the re-read.
module sgd_theta_dump
    import sgd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [FW-1:0]    theta_rd_data,
    input  logic             result_ready,
    output logic [5:0]       theta_rd_idx,
    output logic             result_valid,
    output logic [FW-1:0]    result_data,
    output logic [IDX_W-1:0] result_idx,
    output logic             result_last,
    output logic             finished
);

    logic             active_q, active_d;
    logic             valid_q, valid_d;
    logic             fresh_q, fresh_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    q6_10_t           data_q, data_d;
    logic             accept_s;
    logic             is_last_s;

    assign is_last_s = (idx_q == THETA_LAST);
    assign accept_s  = valid_q && result_ready;

    // Index / valid sequencing: issue index, present beat, bubble after accept.
    always_comb begin
        active_d = active_q;
        valid_d  = valid_q;
        fresh_d  = 1'b0;
        idx_d    = idx_q;
        if (start) begin
            active_d = 1'b1;
            valid_d  = 1'b0;
            idx_d    = {IDX_W{1'b0}};
        end else if (active_q && !valid_q) begin
            valid_d = 1'b1;
            fresh_d = 1'b1;
        end else if (accept_s) begin
            valid_d = 1'b0;
            if (is_last_s) begin
                active_d = 1'b0;
                idx_d    = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + 5'd1;
            end
        end else begin
            fresh_d = 1'b0;
        end
    end

    // First beat cycle passes the core word through; afterwards the copy holds it.
    always_comb begin
        if (valid_q && fresh_q) begin
            data_d = theta_rd_data;
        end else begin
            data_d = data_q;
        end
    end

    // Dump state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            fresh_q  <= 1'b0;
            idx_q    <= {IDX_W{1'b0}};
            data_q   <= 16'sd0;
        end else begin
            active_q <= active_d;
            valid_q  <= valid_d;
            fresh_q  <= fresh_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    assign theta_rd_idx = {1'b0, idx_q};
    assign result_valid = valid_q;
    assign result_data  = data_d;
    assign result_idx   = idx_q;
    assign result_last  = valid_q && is_last_s;
    assign finished     = accept_s && is_last_s;

endmodule

// File: rtl/sgd_feed_ctrl.sv
// Feed sequencer for the SGD core: streams samples from RAM on request,
// counts epochs, and dumps the trained theta vector to the host.
module sgd_feed_ctrl
    import sgd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_start,
    output logic              busy,
    output logic [15:0]       epoch_count,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [FW-1:0]     mem_rd_data,
    output logic              core_start,
    output logic [FW-1:0]     core_feature_in,
    output logic              core_feature_valid,
    output logic [LW-1:0]     core_label_in,
    output logic              core_label_valid,
    input  logic              core_sample_req,
    input  logic              core_done,
    output logic [5:0]        core_theta_rd_idx,
    input  logic [FW-1:0]     core_theta_rd_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [FW-1:0]     result_data,
    output logic [IDX_W-1:0]  result_idx,
    output logic              result_last
);

    feed_state_e       state_q, state_d;
    logic [5:0]        n_q, n_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [15:0]       epoch_q, epoch_d;
    logic              done_seen_q, done_seen_d;
    logic              fv_q, fv_d;
    logic [FW-1:0]     feat_hold_q, feat_hold_d;
    logic [LW-1:0]     label_hold_q, label_hold_d;
    logic              done_pend_s;
    logic              dump_start_s;
    logic              dump_finished_s;

    // A done seen mid-burst is remembered so the burst can finish first.
    assign done_pend_s  = core_done || done_seen_q;
    assign dump_start_s = (state_q == WAIT_REQ) && done_pend_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (host_start) state_d = KICK; else state_d = IDLE;
            KICK:     state_d = WAIT_REQ;
            WAIT_REQ: begin
                if (done_pend_s) begin
                    state_d = DUMP;
                end else if (core_sample_req) begin
                    state_d = FEAT;
                end else begin
                    state_d = WAIT_REQ;
                end
            end
            FEAT:     if (cnt_q == FEAT_CNT_LAST) state_d = LABEL; else state_d = FEAT;
            LABEL:    state_d = WAIT_REQ;
            DUMP:     if (dump_finished_s) state_d = IDLE; else state_d = DUMP;
            default:  state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy             = (state_q != IDLE);
        core_start       = (state_q == KICK);
        mem_rd_en        = (state_q == FEAT);
        core_label_valid = (state_q == LABEL);
    end

    // Sample / address / epoch bookkeeping.
    always_comb begin
        n_d         = n_q;
        base_d      = base_q;
        addr_d      = addr_q;
        cnt_d       = 6'd0;
        epoch_d     = epoch_q;
        done_seen_d = done_seen_q;
        fv_d        = (state_q == FEAT) && (cnt_q != FEAT_CNT_LAST);
        case (state_q)
            IDLE: begin
                done_seen_d = 1'b0;
                if (host_start) begin
                    n_d     = 6'd0;
                    base_d  = {MEM_AW{1'b0}};
                    epoch_d = 16'd0;
                end else begin
                    n_d     = n_q;
                    base_d  = base_q;
                    epoch_d = epoch_q;
                end
            end
            WAIT_REQ: begin
                if (core_sample_req && !done_pend_s) begin
                    addr_d = base_q;
                end else begin
                    addr_d = addr_q;
                end
            end
            FEAT: begin
                done_seen_d = done_seen_q || core_done;
                if (cnt_q != FEAT_CNT_LAST) begin
                    cnt_d  = cnt_q + 6'd1;
                    addr_d = addr_q + MEM_AW'(1);
                end else begin
                    cnt_d  = 6'd0;
                    addr_d = addr_q;
                end
            end
            LABEL: begin
                done_seen_d = done_seen_q || core_done;
                if (n_q == SAMPLE_LAST) begin
                    n_d     = 6'd0;
                    base_d  = {MEM_AW{1'b0}};
                    epoch_d = sat_inc16(epoch_q);
                end else begin
                    n_d     = n_q + 6'd1;
                    base_d  = base_q + SAMPLE_STRIDE;
                    epoch_d = epoch_q;
                end
            end
            default: begin
                done_seen_d = done_seen_q;
            end
        endcase
    end

    // RAM words pass straight through on their valid cycle and are held otherwise.
    always_comb begin
        if (fv_q) begin
            feat_hold_d = mem_rd_data;
        end else begin
            feat_hold_d = feat_hold_q;
        end
        if (state_q == LABEL) begin
            label_hold_d = mem_rd_data[LW-1:0];
        end else begin
            label_hold_d = label_hold_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q          <= 6'd0;
            cnt_q        <= 6'd0;
            base_q       <= {MEM_AW{1'b0}};
            addr_q       <= {MEM_AW{1'b0}};
            epoch_q      <= 16'd0;
            done_seen_q  <= 1'b0;
            fv_q         <= 1'b0;
            feat_hold_q  <= {FW{1'b0}};
            label_hold_q <= {LW{1'b0}};
        end else begin
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            epoch_q      <= epoch_d;
            done_seen_q  <= done_seen_d;
            fv_q         <= fv_d;
            feat_hold_q  <= feat_hold_d;
            label_hold_q <= label_hold_d;
        end
    end

    assign epoch_count        = epoch_q;
    assign mem_rd_addr        = addr_q;
    assign core_feature_valid = fv_q;
    assign core_feature_in    = feat_hold_d;
    assign core_label_in      = label_hold_d;

    sgd_theta_dump u_dump (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (dump_start_s),
        .theta_rd_data (core_theta_rd_data),
        .result_ready  (result_ready),
        .theta_rd_idx  (core_theta_rd_idx),
        .result_valid  (result_valid),
        .result_data   (result_data),
        .result_idx    (result_idx),
        .result_last   (result_last),
        .finished      (dump_finished_s)
    );

endmodule

// File: tb/tb_sgd_feed_ctrl.sv
// Bench for sgd_feed_ctrl: control vector table, model RAM/core, and a stream
// monitor that predicts every feature, label, address and theta beat.
module tb_sgd_feed_ctrl;
    import sgd_pkg::*;

    logic        clk, rst_n, host_start, busy;
    logic [15:0] epoch_count;
    logic        mem_rd_en;
    logic [10:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        core_start;
    logic [15:0] core_feature_in;
    logic        core_feature_valid;
    logic [7:0]  core_label_in;
    logic        core_label_valid, core_sample_req, core_done;
    logic [5:0]  core_theta_rd_idx;
    logic [15:0] core_theta_rd_data;
    logic        result_valid, result_ready;
    logic [15:0] result_data;
    logic [4:0]  result_idx;
    logic        result_last;

    sgd_feed_ctrl dut (
        .clk(clk), .rst_n(rst_n), .host_start(host_start), .busy(busy),
        .epoch_count(epoch_count), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .core_start(core_start),
        .core_feature_in(core_feature_in), .core_feature_valid(core_feature_valid),
        .core_label_in(core_label_in), .core_label_valid(core_label_valid),
        .core_sample_req(core_sample_req), .core_done(core_done),
        .core_theta_rd_idx(core_theta_rd_idx), .core_theta_rd_data(core_theta_rd_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_idx(result_idx), .result_last(result_last)
    );

    logic [15:0] ram   [0:2047];
    logic [15:0] theta [0:63];
    int total = 0;
    int bad = 0;

    // monitor / reference state
    int   ref_n, issue_n, rd_cnt, run_len, n_labels, beat_idx, beats;
    logic prev_fv, epoch_pend, pv, pr, pbub, rdy_rand;
    logic [15:0] last_feat, pdata;
    logic [7:0]  last_lbl;
    logic [4:0]  pidx;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
        core_theta_rd_data <= theta[core_theta_rd_idx];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] theta_of(input int i);
        return 16'((i << Q_FRAC) - 16384);
    endfunction

    // Stream monitor and host-side ready driver.
    initial begin
        result_ready = 1'b0;
        rdy_rand = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_len = 0; rd_cnt = 0; issue_n = 0; ref_n = 0; n_labels = 0;
                prev_fv = 1'b0; last_feat = 16'd0; last_lbl = 8'd0; epoch_pend = 1'b0;
                pv = 1'b0; pr = 1'b0; pbub = 1'b0; beat_idx = 0; beats = 0;
            end else begin
                if (core_start) begin
                    ref_n = 0; issue_n = 0; rd_cnt = 0; run_len = 0;
                    n_labels = 0; beat_idx = 0; beats = 0;
                end
                if (epoch_pend) begin
                    chk("epoch", {16'd0, epoch_count}, n_labels / N_SAMPLES);
                    epoch_pend = 1'b0;
                end
                if (mem_rd_en) begin
                    chk("rd_addr", {21'd0, mem_rd_addr}, issue_n * (N_FEAT + 1) + rd_cnt);
                    rd_cnt++;
                    if (rd_cnt == N_FEAT + 1) begin
                        rd_cnt = 0;
                        issue_n = (issue_n == N_SAMPLES - 1) ? 0 : issue_n + 1;
                    end
                end
                if (core_feature_valid) begin
                    chk("feature", {16'd0, core_feature_in}, ram[ref_n * (N_FEAT + 1) + run_len]);
                    last_feat = core_feature_in;
                    run_len++;
                end else begin
                    chk("feat_hold", {16'd0, core_feature_in}, last_feat);
                end
                if (prev_fv && !core_feature_valid) chk("label_follow", {31'd0, core_label_valid}, 1);
                if (core_label_valid) begin
                    chk("burst_len", run_len, N_FEAT);
                    chk("label", {24'd0, core_label_in}, ram[ref_n * (N_FEAT + 1) + N_FEAT] & 16'h00FF);
                    last_lbl = core_label_in;
                    run_len = 0;
                    n_labels++;
                    ref_n = (ref_n == N_SAMPLES - 1) ? 0 : ref_n + 1;
                    epoch_pend = 1'b1;
                end else begin
                    chk("label_hold", {24'd0, core_label_in}, last_lbl);
                end
                prev_fv = core_feature_valid;

                if (pv && pr) begin
                    beat_idx++; beats++;
                    chk("bubble", {31'd0, result_valid}, 0);
                    if (beat_idx == N_FEAT) chk("busy_drop", {31'd0, busy}, 0);
                end
                if (pbub) chk("rebeat", {31'd0, result_valid}, 1);
                pbub = pv && pr && (beat_idx < N_FEAT);
                if (result_valid) begin
                    if (pv && !pr) begin
                        chk("hold_data", {16'd0, result_data}, pdata);
                        chk("hold_idx", {27'd0, result_idx}, pidx);
                    end else begin
                        chk("beat_idx", {27'd0, result_idx}, beat_idx);
                        chk("beat_data", {16'd0, result_data}, theta_of(beat_idx));
                        chk("beat_last", {31'd0, result_last}, (beat_idx == N_FEAT - 1) ? 1 : 0);
                    end
                end else begin
                    chk("last_low", {31'd0, result_last}, 0);
                end
                pv = result_valid; pdata = result_data; pidx = result_idx;
            end
            pr = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            result_ready = pr;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_run();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        chk("kick_start", {31'd0, core_start}, 1);
        chk("kick_busy", {31'd0, busy}, 1);
        tick();
        chk("start_pulse", {31'd0, core_start}, 0);
    endtask

    task automatic wait_label();
        for (int i = 0; i < 60; i++) begin
            if (core_label_valid) break;
            tick();
        end
        chk("label_seen", {31'd0, core_label_valid}, 1);
        tick();
    endtask

    task automatic req_sample();
        core_sample_req = 1'b1;
        tick();
        core_sample_req = 1'b0;
        wait_label();
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_reached", {31'd0, busy}, 0);
        chk("beats", beats, N_FEAT);
    endtask

    typedef struct {
        logic        hs, rq, bz, cs, en, fv;
        logic [10:0] addr;
        logic [15:0] feat;
    } vec_t;
    vec_t tbl [7];

    initial begin
        rst_n = 1'b0; host_start = 1'b0; core_sample_req = 1'b0; core_done = 1'b0;
        for (int i = 0; i < 2048; i++) ram[i] = 16'd0;
        for (int j = 0; j < N_FEAT; j++) ram[j] = 16'(j * 1024);
        ram[N_FEAT] = 16'd1;
        for (int i = 0; i < 64; i++) theta[i] = (i < N_FEAT) ? theta_of(i) : 16'd0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 16'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd1, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd2, 16'd1024};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd3, 16'd2048};

        // reset, with host_start held high throughout
        host_start = 1'b1;
        repeat (5) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_epoch", {16'd0, epoch_count}, 0);
        chk("rst_outs", {24'd0, mem_rd_en, core_start, core_feature_valid, core_label_valid,
                         result_valid, result_last, 2'b00}, 0);
        chk("rst_data", {core_feature_in, core_label_in, 8'd0}, 0);
        chk("rst_idx", {5'd0, mem_rd_addr, core_theta_rd_idx, result_idx, 5'd0}, 0);
        chk("rst_rdata", {16'd0, result_data}, 0);
        host_start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {30'd0, busy, core_start}, 0);

        // single sample via control vectors
        for (int v = 0; v < 7; v++) begin
            host_start = tbl[v].hs;
            core_sample_req = tbl[v].rq;
            tick();
            chk("vec_busy", {31'd0, busy}, tbl[v].bz);
            chk("vec_start", {31'd0, core_start}, tbl[v].cs);
            chk("vec_rden", {31'd0, mem_rd_en}, tbl[v].en);
            chk("vec_fv", {31'd0, core_feature_valid}, tbl[v].fv);
            chk("vec_addr", {21'd0, mem_rd_addr}, tbl[v].addr);
            chk("vec_feat", {16'd0, core_feature_in}, tbl[v].feat);
        end
        host_start = 1'b0;
        core_sample_req = 1'b0;
        wait_label();
        chk("single_label_cnt", n_labels, 1);
        core_done = 1'b1;
        wait_idle(200);
        core_done = 1'b0;

        // done and request collide in WAIT_REQ: done wins
        start_run();
        core_sample_req = 1'b1;
        core_done = 1'b1;
        tick();
        core_sample_req = 1'b0;
        chk("coll_no_rd", {31'd0, mem_rd_en}, 0);
        chk("coll_dump_entry_valid", {31'd0, result_valid}, 0);
        tick();
        chk("coll_first_beat", {31'd0, result_valid}, 1);
        chk("coll_no_fv", {31'd0, core_feature_valid}, 0);
        wait_idle(200);
        core_done = 1'b0;
        chk("coll_no_labels", n_labels, 0);

        // epoch wrap over 81 random samples, dump with random backpressure
        for (int i = 0; i < N_SAMPLES * (N_FEAT + 1); i++) ram[i] = 16'($urandom);
        start_run();
        for (int s = 0; s < 81; s++) begin
            req_sample();
            if (s == 79) chk("epoch_after_80", {16'd0, epoch_count}, 2);
        end
        rdy_rand = 1'b1;
        core_done = 1'b1;
        wait_idle(1500);
        core_done = 1'b0;
        rdy_rand = 1'b0;
        chk("wrap_labels", n_labels, 81);

        // reset after the 10th feature, then restart with done raised mid-burst
        start_run();
        core_sample_req = 1'b1;
        tick();
        core_sample_req = 1'b0;
        begin
            int k;
            k = 0;
            for (int i = 0; i < 60; i++) begin
                if (core_feature_valid) k++;
                if (k == 10) break;
                tick();
            end
            chk("mid_feat_reached", k, 10);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctl", {29'd0, busy, mem_rd_en, core_feature_valid}, 0);
        chk("arst_data", {core_feature_in, 5'd0, mem_rd_addr}, 0);
        chk("arst_epoch", {16'd0, epoch_count}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", {31'd0, busy}, 0);
        start_run();
        core_sample_req = 1'b1;
        tick();
        core_sample_req = 1'b0;
        repeat (6) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        wait_idle(400);
        chk("done_mid_labels", n_labels, 1);
        chk("done_mid_epoch", {16'd0, epoch_count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sgd_feed_ctrl.md
# sgd_feed_ctrl

Sequencer for the `sgd_lr_int` SGD logistic-regression core. It starts a training run on a host command and serves each `sample_req` from a sample RAM as a gapless burst of N_FEAT Q6.10 features followed by one label. It cycles samples and epochs until the core raises `done`. It then reads the trained theta vector back out of the core and returns it to the host as a ready/valid stream.

## Interface
- N_FEAT, 32: features per sample.
- N_SAMPLES, 40: samples per epoch.
- FW, 16: feature/theta width (Q6.10).
- LW, 8: label width.
- MEM_AW, 11: sample RAM address width; must satisfy 2^MEM_AW ≥ N_SAMPLES·(N_FEAT+1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- host_start  in  1  one-cycle request to start a run; ignored while busy=1.
- busy  out  1  high from the accepted host_start until the last result beat is accepted.
- epoch_count  out  16  number of completed epochs in the current run.
- mem_rd_en  out  1  sample RAM read strobe.
- mem_rd_addr  out  MEM_AW  sample RAM read address.
- mem_rd_data  in  FW  sample RAM data; 1-cycle synchronous read latency.
- core_start  out  1  one-cycle start pulse to the core.
- core_feature_in  out  FW  feature word to the core.
- core_feature_valid  out  1  feature word valid.
- core_label_in  out  LW  label to the core.
- core_label_valid  out  1  label valid.
- core_sample_req  in  1  core is ready to take the next sample.
- core_done  in  1  core has finished training.
- core_theta_rd_idx  out  6  theta read index to the core.
- core_theta_rd_data  in  FW  theta word from the core; valid 1 cycle after the index.
- result_valid  out  1  result beat valid.
- result_ready  in  1  host accepts the result beat.
- result_data  out  FW  theta word.
- result_idx  out  5  theta index of the beat.
- result_last  out  1  high on the beat with result_idx = N_FEAT-1.

## Operation
- Sample RAM layout: sample n occupies base n·(N_FEAT+1).
  - Feature j is at base+j.
  - The label is at base+N_FEAT; it is taken from mem_rd_data[LW-1:0].
- FSM states: IDLE → KICK → WAIT_REQ → FEAT → LABEL → WAIT_REQ … → DUMP → IDLE.
- IDLE: host_start=1 → KICK. The sample index n and epoch_count are cleared to 0.
- KICK: core_start=1 for one cycle, then → WAIT_REQ.
- WAIT_REQ:
  - core_done=1 → DUMP. If core_done and core_sample_req are high in the same cycle, done wins.
  - Otherwise core_sample_req=1 → FEAT.
- FEAT: one read per cycle at base+0 … base+N_FEAT. After the last issue → LABEL.
- LABEL: core_label_valid=1 with the label data, then:
  - n = N_SAMPLES-1: n → 0 and epoch_count increments, saturating at 16'hFFFF.
  - Otherwise n increments.
  - Then → WAIT_REQ.
- core_done during FEAT or LABEL: the current sample burst is always completed before core_done is acted on. The FSM then goes WAIT_REQ → DUMP.
- DUMP:
  - For i = 0…N_FEAT-1: drive core_theta_rd_idx=i; one cycle later present result_valid with result_data=core_theta_rd_data and result_idx=i.
  - Hold the beat stable until result_ready=1.
  - After the accept, i increments and result_valid drops for exactly one cycle (re-read bubble).
  - Accepting the beat with result_last=1 → IDLE.
- host_start while busy=1 has no effect.

## Timing
- Reset values: busy=0, epoch_count=0; all strobes and valids 0 (mem_rd_en, core_start, core_feature_valid, core_label_valid, result_valid, result_last); all data and index outputs 0; state IDLE.
- Reset asserted mid-run clears everything immediately. The core is expected to be reset by the same rst_n.
- Latency from host_start to core_start: 1 cycle (KICK is the cycle after the accept).
- Latency from sampled core_sample_req=1 to the first core_feature_valid: 2 cycles (FEAT entry, then RAM latency).
- core_feature_valid is high for exactly N_FEAT consecutive cycles. core_label_valid follows in the very next cycle, for 1 cycle. No gaps are allowed.
- Feature and label data change only on the cycles where their valid is high; otherwise they hold.
- Minimum result rate is 1 beat per 2 cycles. The first beat appears 1 cycle after DUMP entry.

## Structure
- Package `sgd_pkg` holds:
  - localparams N_FEAT, N_SAMPLES, Q_FRAC=10;
  - typedef `feed_state_e` (IDLE, KICK, WAIT_REQ, FEAT, LABEL, DUMP);
  - typedef `q6_10_t` = logic signed [15:0].
- Sub-module `sgd_theta_dump` contains the DUMP index counter and the result ready/valid holding register, with a start input and a finished output. Everything else stays in the top level.

## Test plan
- Reset then idle: rst_n low 5 cycles → all outputs 0, busy=0; host_start during reset is ignored.
- Single sample feed: RAM words = j·1024 for features, 1 for the label, model core raises sample_req once → 32 consecutive feature_valid beats carrying 0, 1024, …, 31744, then label_valid with label_in=1 on the next cycle.
- Epoch wrap: core requests 81 samples → addresses wrap from base 39·33=1287 back to 0; epoch_count=2 after the 80th label.
- done vs. req collision: core_done and core_sample_req high in the same cycle in WAIT_REQ → no feature_valid is issued; DUMP starts.
- Theta readout with backpressure: model core returns theta[i]=i·1024−16384, result_ready toggled randomly → 32 beats, idx 0…31 in order, data matches, result_last only on idx 31, beat held stable while ready=0, busy drops after the final accept.
- Reset mid-FEAT: rst_n pulled low after the 10th feature → outputs return to 0 asynchronously; the next host_start restarts at n=0.
